// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. The arbiter grants a
//   requester in IDLE (round-robin on contention), latches its opcode and
//   operands, drives the ALU for one EXEC cycle, and then holds a registered
//   response in RESP until the consumer accepts it.
//
// Ports
//   clk, rst_n                          clock (rising edge), synchronous active-low reset
//   req0_* / req1_*                     valid/ready handshake plus opcode and operands per requester
//   alu_opcode, alu_exec, alu_a, alu_b  drive the shared ALU (zero outside EXEC)
//   alu_result                          combinational ALU result
//   rsp_valid, rsp_ready                response handshake
//   rsp_id, rsp_data, rsp_err           issuing requester, result, illegal-opcode flag
//   busy                                high while in EXEC or RESP
//   ops_done                            number of accepted responses (wraps)
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_opcode,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_opcode,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [3:0]       alu_opcode,
   output logic             alu_exec,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

   state_t           state_r, state_s;
   logic             rr_r;          // requester preferred on contention
   logic             id_r;
   logic [3:0]       op_r;
   logic [WIDTH-1:0] a_r, b_r;
   logic             illegal_r;
   logic             rsp_valid_r, rsp_id_r, rsp_err_r;
   logic [WIDTH-1:0] rsp_data_r;
   logic [CNT_W-1:0] ops_r;
   logic             grant_s, grant_id_s;

   // Opcodes above XOR (4) have no ALU meaning.
   function automatic logic is_illegal(input logic [3:0] op);
      return (op > 4'd4);
   endfunction

   // Arbitration: only in IDLE and never while reset is asserted.
   always_comb begin
      grant_s    = 1'b0;
      grant_id_s = 1'b0;
      if ((state_r == ST_IDLE) && rst_n) begin
         if (req0_valid && req1_valid) begin
            grant_s    = 1'b1;
            grant_id_s = rr_r;
         end else if (req0_valid) begin
            grant_s    = 1'b1;
            grant_id_s = 1'b0;
         end else if (req1_valid) begin
            grant_s    = 1'b1;
            grant_id_s = 1'b1;
         end else begin
            grant_s    = 1'b0;
            grant_id_s = 1'b0;
         end
      end else begin
         grant_s    = 1'b0;
         grant_id_s = 1'b0;
      end
   end

   // Next-state logic for the IDLE -> EXEC -> RESP sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_s) state_s = ST_EXEC;
            else         state_s = ST_IDLE;
         end
         ST_EXEC: state_s = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) state_s = ST_IDLE;
            else           state_s = ST_RESP;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // ALU drive: latched operation is presented only during EXEC.
   always_comb begin
      alu_opcode = 4'd0;
      alu_exec   = 1'b0;
      alu_a      = DATA_ZERO;
      alu_b      = DATA_ZERO;
      if (state_r == ST_EXEC) begin
         alu_opcode = op_r;
         alu_exec   = ~illegal_r;
         alu_a      = a_r;
         alu_b      = b_r;
      end else begin
         alu_opcode = 4'd0;
         alu_exec   = 1'b0;
         alu_a      = DATA_ZERO;
         alu_b      = DATA_ZERO;
      end
   end

   // State, operation latch, response register and completion counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         rr_r        <= 1'b0;
         id_r        <= 1'b0;
         op_r        <= 4'd0;
         a_r         <= DATA_ZERO;
         b_r         <= DATA_ZERO;
         illegal_r   <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= 1'b0;
         rsp_data_r  <= DATA_ZERO;
         rsp_err_r   <= 1'b0;
         ops_r       <= CNT_ZERO;
      end else begin
         state_r     <= state_s;
         rsp_valid_r <= (state_s == ST_RESP);
         if (grant_s) begin
            id_r      <= grant_id_s;
            op_r      <= grant_id_s ? req1_opcode : req0_opcode;
            a_r       <= grant_id_s ? req1_a : req0_a;
            b_r       <= grant_id_s ? req1_b : req0_b;
            illegal_r <= is_illegal(grant_id_s ? req1_opcode : req0_opcode);
            rr_r      <= ~grant_id_s;
         end
         // An illegal op never fires the ALU, so its result is forced to zero.
         if (state_r == ST_EXEC) begin
            rsp_data_r <= illegal_r ? DATA_ZERO : alu_result;
            rsp_err_r  <= illegal_r;
            rsp_id_r   <= id_r;
         end
         if ((state_r == ST_RESP) && rsp_ready) begin
            ops_r <= ops_r + CNT_ONE;
         end
      end
   end

   assign req0_ready = grant_s & ~grant_id_s;
   assign req1_ready = grant_s &  grant_id_s;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_id     = rsp_id_r;
   assign rsp_data   = rsp_data_r;
   assign rsp_err    = rsp_err_r;
   assign busy       = (state_r != ST_IDLE);
   assign ops_done   = ops_r;

endmodule
